wb_register_file: RTL

Architectural register file at the far end of the writeback pipeline register: consumes the two writeback streams (result write and base-register update) and commits them into sixteen 32-bit ARM registers r0–r15. Provides three asynchronous read ports to decode/operand fetch. Flags any commit to r15 as a registered PC-redirect pulse for the fetch stage.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_register_file_if.sv | 42 ++++
 rtl/wb_write_arbiter.sv | 38 +++
 rtl/wb_register_file.sv | 77 +++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback register file.
// Latency: n/a (declarations only). Backpressure: n/a.
// Consumed by the interface, arbiter and register file via import wb_pkg::*.
package wb_pkg;

    localparam int WB_CTRL_RESULT = 0;
    localparam int WB_CTRL_BASE   = 1;
    localparam int REG_ADDR_W     = 4;
    localparam int REG_COUNT      = 16;

    localparam logic [REG_ADDR_W-1:0] REG_PC = 4'd15;

    typedef logic [31:0] reg_word_t;

    // True when an enabled write port targets register index idx.
    function automatic logic addr_hit(input logic                  en,
                                      input logic [REG_ADDR_W-1:0] addr,
                                      input int                    idx);
        return en && (addr == REG_ADDR_W'(idx));
    endfunction

endpackage

// File: rtl/wb_register_file_if.sv
// Writeback-to-register-file bus: two write streams, three read ports, PC redirect.
// Latency: n/a (wiring only). Backpressure: none, writes are always accepted.
// master = writeback/decode side, slave = register file.
interface wb_register_file_if
    import wb_pkg::*;
#(
    parameter int wb_control_width = 2
);

    logic [wb_control_width-1:0] wb_control;
    reg_word_t                   wb_content;
    logic [REG_ADDR_W-1:0]       wb_add;
    reg_word_t                   base_register_update_content;
    logic [REG_ADDR_W-1:0]       reg_update_address;

    logic [REG_ADDR_W-1:0]       rd_addr_0;
    logic [REG_ADDR_W-1:0]       rd_addr_1;
    logic [REG_ADDR_W-1:0]       rd_addr_2;
    reg_word_t                   rd_data_0;
    reg_word_t                   rd_data_1;
    reg_word_t                   rd_data_2;

    logic                        pc_redirect;
    reg_word_t                   pc_redirect_value;

    modport master (
        output wb_control, wb_content, wb_add,
        output base_register_update_content, reg_update_address,
        output rd_addr_0, rd_addr_1, rd_addr_2,
        input  rd_data_0, rd_data_1, rd_data_2,
        input  pc_redirect, pc_redirect_value
    );

    modport slave (
        input  wb_control, wb_content, wb_add,
        input  base_register_update_content, reg_update_address,
        input  rd_addr_0, rd_addr_1, rd_addr_2,
        output rd_data_0, rd_data_1, rd_data_2,
        output pc_redirect, pc_redirect_value
    );

endinterface

// File: rtl/wb_write_arbiter.sv
// Resolves port A (result) / port B (base update) into per-register write enables and data.
// Latency: combinational. Backpressure: none; on a same-address clash port B is dropped.
// Shared by the array update and the optional same-cycle read bypass.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int reg_count = REG_COUNT
) (
    input  logic [1:0]            ctrl,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  reg_word_t             a_data,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  reg_word_t             b_data,
    output logic [reg_count-1:0]  we,
    output reg_word_t             wdata [reg_count]
);

    logic a_en;
    logic b_en;

    // Load data beats base writeback when both target the same register.
    assign a_en = ctrl[WB_CTRL_RESULT];
    assign b_en = ctrl[WB_CTRL_BASE] && !(a_en && (a_addr == b_addr));

    always_comb begin
        we = '0;
        for (int i = 0; i < reg_count; i++) begin
            wdata[i] = b_data;
            if (addr_hit(a_en, a_addr, i)) begin
                we[i]    = 1'b1;
                wdata[i] = a_data;
            end else if (addr_hit(b_en, b_addr, i)) begin
                we[i]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_register_file.sv
// Sixteen-entry ARM register file committing both writeback streams; r15 commits pulse pc_redirect.
// Latency: writes visible 1 cycle later (same cycle with WB_RF_BYPASS_EN); reads combinational.
// Backpressure: none, every enabled write commits; reset is synchronous active-low on `reset`.
module wb_register_file
    import wb_pkg::*;
#(
    parameter int reg_count = REG_COUNT
) (
    input  logic               clock,
    input  logic               reset,
    wb_register_file_if.slave  bus
);

    reg_word_t             regs [reg_count];
    logic [reg_count-1:0]  we;
    reg_word_t             wdata [reg_count];
    logic                  pc_redirect_q;
    reg_word_t             pc_redirect_value_q;

    logic [REG_ADDR_W-1:0] rd_addr [3];
    reg_word_t             rd_data [3];

    wb_write_arbiter #(
        .reg_count (reg_count)
    ) u_arbiter (
        .ctrl   (bus.wb_control[WB_CTRL_BASE:WB_CTRL_RESULT]),
        .a_addr (bus.wb_add),
        .a_data (bus.wb_content),
        .b_addr (bus.reg_update_address),
        .b_data (bus.base_register_update_content),
        .we     (we),
        .wdata  (wdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < reg_count; i++) begin
                regs[i] <= '0;
            end
            pc_redirect_q       <= 1'b0;
            pc_redirect_value_q <= '0;
        end else begin
            for (int i = 0; i < reg_count; i++) begin
                if (we[i]) begin
                    regs[i] <= wdata[i];
                end
            end
            pc_redirect_q <= we[REG_PC];
            if (we[REG_PC]) begin
                pc_redirect_value_q <= wdata[REG_PC];
            end
        end
    end

    assign rd_addr[0] = bus.rd_addr_0;
    assign rd_addr[1] = bus.rd_addr_1;
    assign rd_addr[2] = bus.rd_addr_2;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_data[k] = regs[rd_addr[k]];
`ifdef WB_RF_BYPASS_EN
            // Forward the priority-resolved write so decode sees it this cycle.
            if (we[rd_addr[k]]) begin
                rd_data[k] = wdata[rd_addr[k]];
            end
`endif
        end
    end

    assign bus.rd_data_0         = rd_data[0];
    assign bus.rd_data_1         = rd_data[1];
    assign bus.rd_data_2         = rd_data[2];
    assign bus.pc_redirect       = pc_redirect_q;
    assign bus.pc_redirect_value = pc_redirect_value_q;

endmodule
